// File: rtl/mcycle_if.sv
// Decoder-to-multiply/divide unit bundle: request, operands, results and stall.
// The decoder side drives the request; the unit side returns results and Busy.
interface mcycle_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// operating on magnitudes with the signs re-applied at completion.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic   CLK,
  input  logic   RESETn,
  mcycle_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_res;   // product / quotient must be negated
  logic             neg_rem;   // remainder takes the dividend's sign
  logic             div0;
  logic [WIDTH-1:0] op1_raw;
  logic [WIDTH-1:0] m_val;     // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] hi;        // accumulator upper half / partial remainder
  logic [WIDTH-1:0] lo;        // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;

  // Operand conditioning at acceptance
  logic             is_signed;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  assign is_signed = ~bus.MCycleOp[0];
  assign neg1      = is_signed & bus.Operand1[WIDTH-1];
  assign neg2      = is_signed & bus.Operand2[WIDTH-1];
  assign abs1      = neg1 ? -bus.Operand1 : bus.Operand1;
  assign abs2      = neg2 ? -bus.Operand2 : bus.Operand2;

  // One iteration of either algorithm
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    sum     = '0;
    shifted = '0;
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (!is_div) begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, m_val} : '0);
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else begin
      shifted = {hi, lo[WIDTH-1]};
      if (shifted >= {1'b0, m_val}) begin
        shifted = shifted - {1'b0, m_val};
        lo_nxt  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        lo_nxt  = {lo[WIDTH-2:0], 1'b0};
      end
      hi_nxt = shifted[WIDTH-1:0];
    end
  end

  assign prod     = {hi_nxt, lo_nxt};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -lo_nxt : lo_nxt;
  assign rem_fix  = neg_rem ? -hi_nxt : hi_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, including the datapath, are reset so no X ever reaches the outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      op1_raw <= '0;
      m_val   <= '0;
      hi      <= '0;
      lo      <= '0;
      res1    <= '0;
      res2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            is_div  <= bus.MCycleOp[1];
            neg_res <= neg1 ^ neg2;
            neg_rem <= neg1;
            div0    <= bus.MCycleOp[1] & (bus.Operand2 == '0);
            op1_raw <= bus.Operand1;
            m_val   <= bus.MCycleOp[1] ? abs2 : abs1;
            lo      <= bus.MCycleOp[1] ? abs1 : abs2;
            hi      <= '0;
            count   <= '0;
            state   <= COMPUTING;
          end
        end
        COMPUTING: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            count <= '0;
            state <= DONE;
            if (!is_div) begin
              res1 <= prod_fix[WIDTH-1:0];
              res2 <= prod_fix[2*WIDTH-1:WIDTH];
            end else if (div0) begin
              res1 <= '1;
              res2 <= op1_raw;
            end else begin
              res1 <= quo_fix;
              res2 <= rem_fix;
            end
          end
        end
        // Unconditional return keeps a still-asserted Start from retriggering.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = (state == IDLE) ? bus.Start : (state == COMPUTING);
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed table-driven bench for mcycle_unit: results, latency, operand
// isolation while computing, no-retrigger, back-to-back and mid-op reset.
module tb_mcycle_unit;
  localparam int W = 32;

  logic CLK;
  logic RESETn;
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;

  mcycle_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the DONE negedge if keep, else one cycle later.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r1, input logic [31:0] r2,
                       input bit keep, output int done_cyc);
    int n;
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    #1;
    check({name, " accept_busy"}, 64'(bus.Busy), 64'd1);
    @(negedge CLK);
    n = 1;
    while (bus.Busy && n < 100) begin
      bus.MCycleOp = 2'($urandom);
      bus.Operand1 = $urandom;
      bus.Operand2 = $urandom;
      n++;
      @(negedge CLK);
    end
    done_cyc = cyc;
    check({name, " busy_cycles"}, 64'(n), 64'd33);
    check({name, " done_busy"}, 64'(bus.Busy), 64'd0);
    check({name, " result1"}, 64'(bus.Result1), 64'(r1));
    check({name, " result2"}, 64'(bus.Result2), 64'(r2));
    if (!keep) begin
      bus.Start = 1'b0;
      @(negedge CLK);
      check({name, " idle_busy"}, 64'(bus.Busy), 64'd0);
      check({name, " held"}, {bus.Result2, bus.Result1}, {r2, r1});
    end
  endtask

  initial begin
    int t0, t1;
    vecs[0]  = '{"smul_neg3x7",   2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vecs[1]  = '{"umul_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"sdiv_neg7_2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[3]  = '{"udiv_100_7",    2'b11, 32'd100,      32'd7,        32'd14,       32'd2};
    vecs[4]  = '{"sdiv_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[5]  = '{"sdiv_5_0",      2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
    vecs[6]  = '{"sdiv_neg5_0",   2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[7]  = '{"udiv_big_0",    2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[8]  = '{"smul_min_neg1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[9]  = '{"sdiv_7_neg2",   2'b10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[10] = '{"udiv_max_10",   2'b11, 32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd5};
    vecs[11] = '{"smul_pos",      2'b00, 32'h00012345, 32'h00010000, 32'h23450000, 32'h00000001};
    vecs[12] = '{"umul_min_2",    2'b01, 32'h80000000, 32'd2,        32'h00000000, 32'h00000001};
    vecs[13] = '{"sdiv_neg_neg",  2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};

    RESETn       = 1'b0;
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    #3;
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_results", {bus.Result2, bus.Result1}, 64'd0);
    bus.Start = 1'b1;
    #1;
    check("reset_busy_follows_start", 64'(bus.Busy), 64'd1);
    bus.Start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r1, vecs[i].r2, 1'b0, t0);

    // Start held through DONE must not retrigger
    do_op("hold_start", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, t0);
    @(negedge CLK);
    bus.Start = 1'b0;
    #1;
    check("no_retrigger_busy", 64'(bus.Busy), 64'd0);
    check("no_retrigger_held", {bus.Result2, bus.Result1}, {32'd2, 32'd14});
    @(negedge CLK);
    check("no_retrigger_idle", 64'(bus.Busy), 64'd0);

    // Back-to-back: second request presented during DONE, accepted in the following IDLE
    do_op("b2b_first", 2'b01, 32'd3, 32'd5, 32'd15, 32'd0, 1'b1, t0);
    bus.MCycleOp = 2'b00;
    bus.Operand1 = 32'hFFFFFFFE;
    bus.Operand2 = 32'd3;
    @(negedge CLK);
    do_op("b2b_second", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, t1);
    check("b2b_spacing", 64'(t1 - t0), 64'd34);

    // Reset asserted in the middle of a computation
    bus.Start    = 1'b1;
    bus.MCycleOp = 2'b01;
    bus.Operand1 = 32'd9;
    bus.Operand2 = 32'd9;
    repeat (11) @(negedge CLK);
    check("pre_reset_busy", 64'(bus.Busy), 64'd1);
    RESETn = 1'b0;
    #1;
    check("midreset_results", {bus.Result2, bus.Result1}, 64'd0);
    check("midreset_busy_start", 64'(bus.Busy), 64'd1);
    bus.Start = 1'b0;
    #1;
    check("midreset_busy_idle", 64'(bus.Busy), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", 64'(bus.Busy), 64'd0);
    do_op("post_reset_op", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, t0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the M-extension.
- Directly downstream of the instruction decoder: consumes MCycleStart and MCycleOp, plus the rs1/rs2 operands from the execute stage.
- Produces a low/quotient result and a high/remainder result; the decoder's MCycleResultSel chooses between them.
- Asserts Busy so the pipeline stalls for the full duration of the operation.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- Start  input  1  level request from the decoder (MCycleStart); held high while the instruction sits in execute.
- MCycleOp  input  2  operation: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- Operand1  input  WIDTH  rs1 value (multiplicand / dividend).
- Operand2  input  WIDTH  rs2 value (multiplier / divisor).
- Result1  output  WIDTH  product low half / quotient.
- Result2  output  WIDTH  product high half / remainder.
- Busy  output  1  stall request to the pipeline.

Behaviour:
- Clock and reset: one clock, CLK; reset RESETn is asynchronous and active-low.
- Reset: state=IDLE, counter=0, Result1=0, Result2=0, all internal registers cleared. Busy=0 unless Start is high.
- Reset mid-operation aborts immediately to IDLE with zeroed results.
- States: IDLE, COMPUTING, DONE.
- IDLE:
  - Busy = Start (combinational).
  - On an edge with Start=1: latch MCycleOp, latch |Operand1| and |Operand2| (absolute values for signed ops, raw for unsigned), record the result signs, clear counter, go to COMPUTING.
- COMPUTING:
  - Busy=1. Start and operand inputs are ignored; operands are not re-sampled.
  - One iteration per cycle; counter increments.
  - After WIDTH iterations (counter==WIDTH-1 on the edge): write Result1/Result2 and go to DONE.
- DONE:
  - Busy=0 for exactly one cycle, so the stalled instruction advances.
  - Results are valid and held.
  - Always returns to IDLE on the next edge, even if Start=1, so the still-present Start of the same instruction cannot retrigger.
- Latency: Busy high for WIDTH+1 consecutive cycles (acceptance cycle plus WIDTH compute cycles), then low in DONE. Results are stable from DONE until the next accepted Start's completion.
- Back-to-back: a new Start sampled in the IDLE cycle immediately after DONE is accepted normally.
- Multiply:
  - Shift-add on a 2*WIDTH accumulator: if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1.
  - Unsigned result is exact, 2*WIDTH bits.
  - Signed: if sign(Op1) XOR sign(Op2), negate the 2*WIDTH product (two's complement).
  - Result1 = product[WIDTH-1:0]; Result2 = product[2*WIDTH-1:WIDTH].
- Divide:
  - Restoring divide: shift the remainder left taking the next dividend MSB; subtract the divisor if the remainder >= divisor and set the quotient bit.
  - Signed: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero (divisor==0), detected at acceptance: Result1 = all ones; Result2 = Operand1 as latched (original signed value). Same latency; no early exit.
- Signed overflow (Operand1 = -2^(WIDTH-1), Operand2 = -1): Result1 = -2^(WIDTH-1), Result2 = 0. This falls out of the absolute-value datapath with no special case, but must be verified.
- Absolute value of -2^(WIDTH-1) is represented as the unsigned value 2^(WIDTH-1); no overflow occurs inside the datapath.
- No X on outputs after reset. MCycleOp changes outside IDLE have no effect.

Test Plan:
- Signed mul: Op1=0xFFFFFFFD (-3), Op2=7, op 00 -> Busy high 33 cycles, then Result1=0xFFFFFFEB, Result2=0xFFFFFFFF, Busy=0 for one cycle.
- Unsigned mul: 0xFFFFFFFF x 0xFFFFFFFF, op 01 -> Result1=0x00000001, Result2=0xFFFFFFFE.
- Signed div: -7 / 2, op 10 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1).
- Unsigned div: 100 / 7, op 11 -> Result1=14, Result2=2.
- Division corner cases:
  - 0x80000000 / 0xFFFFFFFF, op 10 -> Result1=0x80000000, Result2=0.
  - 5 / 0, op 10 -> Result1=0xFFFFFFFF, Result2=5.
  - -5 / 0 -> Result2=0xFFFFFFFB.
- Control:
  - Start held high through DONE -> no retrigger; next operation accepted only from IDLE.
  - RESETn pulsed low at compute cycle 10 -> immediately IDLE, Result1=Result2=0, Busy=Start.
  - Back-to-back muls -> second completes 34 cycles after the first's DONE.
